// File: rtl/blink_pkg.sv
// Shared constants for the Blink RTC block: I/O port addresses,
// status bit positions and the status-width helper.
package blink_pkg;

  // I/O port addresses (Z80 A7..A0)
  localparam logic [7:0] A_TACK = 8'hB4;  // write: clear status bits
  localparam logic [7:0] A_TMK  = 8'hB5;  // write: mask, read: status
  localparam logic [7:0] A_TIM0 = 8'hD0;  // read: tim0, captures snapshot
  localparam logic [7:0] A_SNP1 = 8'hD1;  // read: snapshot tim1
  localparam logic [7:0] A_SNP2 = 8'hD2;  // read: snapshot timm[7:0]
  localparam logic [7:0] A_SNP3 = 8'hD3;  // read: snapshot timm[15:8]
  localparam logic [7:0] A_SNP4 = 8'hD4;  // read: snapshot timm[TM_W-1:16]
  localparam logic [7:0] A_ALM  = 8'hE0;  // alarm k low byte at E0+2k, high at E1+2k

  // Status bit positions
  localparam int ST_TICK = 0;
  localparam int ST_SEC  = 1;
  localparam int ST_MIN  = 2;
  localparam int ST_ALM0 = 3;

  // Status vector width for a given number of alarm channels
  function automatic int ns_width(input int n_alarm);
    return ST_ALM0 + n_alarm;
  endfunction

endpackage

// File: rtl/blink_rtc_counter.sv
// Prescaler and tim0/tim1/timm counter cascade. Pulses are combinational
// from the current counts so that the wrap and the status set share an edge.
module blink_rtc_counter #(
  parameter int TICK_DIV = 49152,
  parameter int T0_MOD   = 200,
  parameter int T1_MOD   = 60,
  parameter int TM_W     = 21
) (
  input  logic            i_mck,
  input  logic            i_rin,
  input  logic            i_hold,
  output logic [7:0]      o_tim0,
  output logic [5:0]      o_tim1,
  output logic [TM_W-1:0] o_timm,
  output logic            o_tick,
  output logic            o_sec,
  output logic            o_min
);

  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0]   r_tck;
  logic [7:0]      r_tim0;
  logic [5:0]      r_tim1;
  logic [TM_W-1:0] r_timm;

  // Carries ripple combinationally; a held counter produces no pulses
  assign o_tick = ~i_hold & (r_tck == TW'(TICK_DIV - 1));
  assign o_sec  = o_tick & (r_tim0 == 8'(T0_MOD - 1));
  assign o_min  = o_sec & (r_tim1 == 6'(T1_MOD - 1));

  assign o_tim0 = r_tim0;
  assign o_tim1 = r_tim1;
  assign o_timm = r_timm;

  // Prescaler and cascade; all carries land on the same edge
  always_ff @(posedge i_mck) begin
    if (i_rin || i_hold) begin
      r_tck  <= '0;
      r_tim0 <= 8'h00;
      r_tim1 <= 6'h00;
      r_timm <= '0;
    end else begin
      r_tck <= o_tick ? '0 : r_tck + TW'(1);
      if (o_tick) begin
        r_tim0 <= o_sec ? 8'h00 : r_tim0 + 8'h01;
      end
      if (o_sec) begin
        r_tim1 <= o_min ? 6'h00 : r_tim1 + 6'h01;
      end
      if (o_min) begin
        r_timm <= r_timm + TM_W'(1);
      end
    end
  end

endmodule

// File: rtl/blink_rtc.sv
// Blink RTC: counter cascade, sticky status with mask, minute alarms,
// coherent snapshot of {tim1,timm} on tim0 reads, registered read port.
module blink_rtc import blink_pkg::*; #(
  parameter int TICK_DIV = 49152,
  parameter int T0_MOD   = 200,
  parameter int T1_MOD   = 60,
  parameter int TM_W     = 21,
  parameter int N_ALARM  = 2,
  localparam int NS      = ns_width(N_ALARM)
) (
  input  logic          mck,
  input  logic          rin,
  input  logic          rtc_rst,
  input  logic          io_wr,
  input  logic          io_rd,
  input  logic [7:0]    io_addr,
  input  logic [7:0]    io_wdata,
  output logic [7:0]    io_rdata,
  output logic [NS-1:0] tsta,
  output logic          rtc_int
);

  // At least one alarm slot so the arrays stay legal when N_ALARM is 0
  localparam int NA = (N_ALARM > 0) ? N_ALARM : 1;

  logic [7:0]      w_tim0;
  logic [5:0]      w_tim1;
  logic [TM_W-1:0] w_timm;
  logic            w_tick, w_sec, w_min;
  logic [15:0]     w_timm_new;

  logic [NS-1:0]   r_tsta, r_tmk, w_set, w_clr;
  logic [15:0]     r_alm [NA];
  logic [5:0]      r_snap_tim1;
  logic [TM_W-1:0] r_snap_timm;
  logic [7:0]      r_rdata;

  logic [NA-1:0]   w_lo_sel, w_hi_sel;
  logic            w_rd_hit;
  logic [7:0]      w_rd_data;

  blink_rtc_counter #(
    .TICK_DIV (TICK_DIV),
    .T0_MOD   (T0_MOD),
    .T1_MOD   (T1_MOD),
    .TM_W     (TM_W)
  ) u_counter (
    .i_mck  (mck),
    .i_rin  (rin),
    .i_hold (rtc_rst),
    .o_tim0 (w_tim0),
    .o_tim1 (w_tim1),
    .o_timm (w_timm),
    .o_tick (w_tick),
    .o_sec  (w_sec),
    .o_min  (w_min)
  );

  // Alarms compare against the minute value the pulse is about to load
  assign w_timm_new = 16'(w_timm + TM_W'(1));

  // Only implemented channels decode; higher alarm addresses stay unmapped
  for (genvar k = 0; k < NA; k++) begin : g_alm_sel
    assign w_lo_sel[k] = (k < N_ALARM) && (io_addr == A_ALM + 8'(2 * k));
    assign w_hi_sel[k] = (k < N_ALARM) && (io_addr == A_ALM + 8'(2 * k + 1));
  end

  assign w_clr    = (io_wr && (io_addr == A_TACK)) ? io_wdata[NS-1:0] : '0;
  assign tsta     = r_tsta;
  assign rtc_int  = |(r_tsta & r_tmk);
  assign io_rdata = r_rdata;

  // Status set sources for this edge
  always_comb begin
    w_set          = '0;
    w_set[ST_TICK] = w_tick;
    w_set[ST_SEC]  = w_sec;
    w_set[ST_MIN]  = w_min;
    for (int k = 0; k < N_ALARM; k++) begin
      w_set[ST_ALM0 + k] = w_min & (w_timm_new == r_alm[k]);
    end
  end

  // Read data selection; w_rd_hit low means the address is unmapped
  always_comb begin
    w_rd_hit  = 1'b1;
    w_rd_data = 8'h00;
    case (io_addr)
      A_TMK:   w_rd_data = 8'(r_tsta);
      A_TIM0:  w_rd_data = w_tim0;
      A_SNP1:  w_rd_data = {2'b00, r_snap_tim1};
      A_SNP2:  w_rd_data = r_snap_timm[7:0];
      A_SNP3:  w_rd_data = r_snap_timm[15:8];
      A_SNP4:  w_rd_data = 8'(r_snap_timm[TM_W-1:16]);
      default: begin
        w_rd_hit = (|w_lo_sel) | (|w_hi_sel);
        for (int k = 0; k < NA; k++) begin
          w_rd_data = w_rd_data | ({8{w_lo_sel[k]}} & r_alm[k][7:0])
                                | ({8{w_hi_sel[k]}} & r_alm[k][15:8]);
        end
      end
    endcase
  end

  // Sticky status: a set in the same cycle as a clear wins
  always_ff @(posedge mck) begin
    if (rin) begin
      r_tsta <= '0;
    end else begin
      r_tsta <= (r_tsta & ~w_clr) | w_set;
    end
  end

  // Interrupt mask and alarm compare registers
  always_ff @(posedge mck) begin
    if (rin) begin
      r_tmk <= '0;
      for (int k = 0; k < NA; k++) begin
        r_alm[k] <= 16'h0000;
      end
    end else begin
      if (io_wr && (io_addr == A_TMK)) begin
        r_tmk <= io_wdata[NS-1:0];
      end
      for (int k = 0; k < NA; k++) begin
        if (io_wr && w_lo_sel[k]) begin
          r_alm[k][7:0] <= io_wdata;
        end
        if (io_wr && w_hi_sel[k]) begin
          r_alm[k][15:8] <= io_wdata;
        end
      end
    end
  end

  // Registered read port and snapshot captured alongside tim0
  always_ff @(posedge mck) begin
    if (rin) begin
      r_rdata     <= 8'h00;
      r_snap_tim1 <= 6'h00;
      r_snap_timm <= '0;
    end else begin
      if (io_rd && w_rd_hit) begin
        r_rdata <= w_rd_data;
      end
      if (io_rd && (io_addr == A_TIM0)) begin
        r_snap_tim1 <= w_tim1;
        r_snap_timm <= w_timm;
      end
    end
  end

endmodule
